hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 8 +
 rtl/hazard_busy_cnt.sv | 17 +
 rtl/hazard_scoreboard.sv | 92 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: producer latency classes, latency width and scoreboard FSM encoding.
package hazard_pkg;
   localparam int LAT_W = 4;
   localparam logic [LAT_W-1:0] LAT_ALU = 4'd1;
   localparam logic [LAT_W-1:0] LAT_LOAD = 4'd2;
   localparam logic [LAT_W-1:0] LAT_MUL = 4'd4;
   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/hazard_busy_cnt.sv
// hazard_busy_cnt: per-register cycles-until-forwardable counter; a load beats the decrement.
module hazard_busy_cnt
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [LAT_W-1:0] i_lat,
   output logic [LAT_W-1:0] o_busy
);
   logic [LAT_W-1:0] r_busy;
   always_ff @(posedge clk)
      if (rst) r_busy <= '0;
      else if (i_load) r_busy <= i_lat;
      else if (r_busy != '0) r_busy <= r_busy - 1'b1;
   assign o_busy = r_busy;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register busy scoreboard producing stall/bubble and redirect flush controls.
// Define HAZARD_PERF_CNT_EN to build saturating stall/flush performance counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int MAX_LAT = int'(LAT_MUL),
   parameter int FLUSH_DEPTH = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        id_valid,
   input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
   input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
   input  logic                        id_use_rs1,
   input  logic                        id_use_rs2,
   input  logic [$clog2(NUM_REGS)-1:0] id_rd,
   input  logic                        id_regwrite,
   input  logic [3:0]                  id_lat,
   input  logic                        redirect,
   output logic                        pc_write,
   output logic                        if_id_write,
   output logic                        id_ex_bubble,
   output logic                        if_id_flush,
   output logic                        id_ex_flush,
   output logic [31:0]                 stall_cnt,
   output logic [31:0]                 flush_cnt
);
   localparam int RW = $clog2(NUM_REGS);
   logic [LAT_W-1:0] w_busy [NUM_REGS];
   logic [LAT_W-1:0] w_lat;
   logic w_hazard, w_flush_active, w_stall, w_issue;
   state_t r_state, w_state_nxt;
   logic [2:0] r_rem, w_rem_nxt;
   assign w_lat = (id_lat < LAT_ALU) ? LAT_ALU : (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;
   // A busy value of 1 means the result is forwardable next cycle, so only >1 stalls.
   assign w_hazard = id_valid & ((id_use_rs1 & (w_busy[id_rs1] > 4'd1)) |
                                 (id_use_rs2 & (w_busy[id_rs2] > 4'd1)));
   assign w_flush_active = redirect | (r_state == FLUSH);
   assign w_stall = w_hazard & ~w_flush_active;
   assign w_issue = id_valid & ~w_hazard & ~w_flush_active & id_regwrite & (id_rd != '0);
   assign w_busy[0] = '0;
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_busy
      hazard_busy_cnt u_cnt (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_issue && (id_rd == RW'(g))),
         .i_lat  (w_lat),
         .o_busy (w_busy[g])
      );
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_state <= IDLE;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   always_comb begin
      w_state_nxt  = r_state;
      w_rem_nxt    = r_rem;
      pc_write     = ~rst & ~w_stall;
      if_id_write  = ~rst & ~w_stall;
      id_ex_bubble = rst | w_stall;
      if_id_flush  = rst | w_flush_active;
      id_ex_flush  = rst | w_flush_active;
      if (redirect) begin
         w_state_nxt = (FLUSH_DEPTH > 1) ? FLUSH : IDLE;
         w_rem_nxt   = 3'(FLUSH_DEPTH - 1);
      end else if (r_state == FLUSH) begin
         w_state_nxt = (r_rem <= 3'd1) ? IDLE : FLUSH;
         w_rem_nxt   = r_rem - 3'd1;
      end
   end
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_stall_cnt, r_flush_cnt;
   always_ff @(posedge clk)
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush_active && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule
